// File: rtl/fifo_drain_ctrl.sv
// Drain controller between an rx FIFO and the UART tx: watermark
// start/stop, paced single-word pops, optional FILL timeout flush.
// Optional timeout: define DRAIN_TIMEOUT_EN to build the FILL timer.
// Ports: clk, reset_n (async low); occ, fifo_full, fifo_empty,
// tx_ready in; rd_en, draining, flush_evt, ovf out (all registered).
module fifo_drain_ctrl #(
  parameter int CNT_W   = 5,
  parameter int HI_MARK = 16,
  parameter int LO_MARK = 0,
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] occ,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic             tx_ready,
  output logic             rd_en,
  output logic             draining,
  output logic             flush_evt,
  output logic             ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_POP,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] HI_C = CNT_W'(HI_MARK);
  localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO_MARK);
  localparam bit LO_EN = (LO_MARK > 0);

  state_t r_state;
  state_t w_next;
  logic   w_flush;
  logic   w_hi;
  logic   w_lo;
  logic   w_to;
  logic   w_drn;

  logic r_rd_en;
  logic r_draining;
  logic r_flush;
  logic r_ovf;

  assign w_hi = (occ >= HI_C) || fifo_full;
  assign w_lo = LO_EN && (occ <= LO_C);

`ifdef DRAIN_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_timer;
  logic [TO_W-1:0] w_timer_nxt;

  assign w_to = (r_timer == TO_LAST);

  // Counts only while staying in FILL; any entry
  // into FILL (or leaving it) restarts from 0.
  always_comb begin
    w_timer_nxt = '0;
    if (r_state == S_FILL && w_next == S_FILL) begin
      if (&r_timer) w_timer_nxt = r_timer;
      else          w_timer_nxt = r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_timer <= '0;
    else          r_timer <= w_timer_nxt;
  end
`else
  assign w_to = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_flush = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!fifo_empty) w_next = S_FILL;
      end
      S_FILL: begin
        if (fifo_empty) begin
          w_next = S_IDLE;
        end else if (w_hi) begin
          w_next = S_DRAIN;
        end else if (w_to) begin
          w_next  = S_DRAIN;
          w_flush = 1'b1;
        end
      end
      S_DRAIN: begin
        if (fifo_empty)    w_next = S_IDLE;
        else if (w_lo)     w_next = S_FILL;
        else if (tx_ready) w_next = S_POP;
      end
      S_POP:   w_next = S_GAP;
      S_GAP:   w_next = S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_drn = (w_next == S_DRAIN) ||
                 (w_next == S_POP) ||
                 (w_next == S_GAP);

  // Outputs are decoded from the next state and
  // registered with it, so they track r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rd_en    <= 1'b0;
      r_draining <= 1'b0;
      r_flush    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_en    <= (w_next == S_POP);
      r_draining <= w_drn;
      r_flush    <= w_flush;
      if (fifo_full &&
          (r_state == S_IDLE || r_state == S_FILL))
        r_ovf <= 1'b1;
    end
  end

  assign rd_en     = r_rd_en;
  assign draining  = r_draining;
  assign flush_evt = r_flush;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: two instances (LO_MARK 0 and 4) share
// stimulus and are checked each cycle against a behavioural model.
module tb_fifo_drain_ctrl;

`ifdef DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int HI = 16;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] occ = '0;
  logic       full = 1'b0;
  logic       empty = 1'b1;
  logic       txr = 1'b0;
  logic       rd0, dr0, fl0, ov0;
  logic       rd1, dr1, fl1, ov1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl u0 (
    .clk(clk), .reset_n(reset_n), .occ(occ),
    .fifo_full(full), .fifo_empty(empty),
    .tx_ready(txr), .rd_en(rd0), .draining(dr0),
    .flush_evt(fl0), .ovf(ov0)
  );

  fifo_drain_ctrl #(.LO_MARK(4)) u1 (
    .clk(clk), .reset_n(reset_n), .occ(occ),
    .fifo_full(full), .fifo_empty(empty),
    .tx_ready(txr), .rd_en(rd1), .draining(dr1),
    .flush_evt(fl1), .ovf(ov1)
  );

  // Model: act = not idle, drn = in a drain burst,
  // age = cycles spent filling, pace = 2 pop, 1 settle, 0 ready.
  typedef struct {
    bit act; bit drn; int age; int pace;
    bit rd; bit fl; bit ov;
  } mdl_t;

  mdl_t m [2];
  int   lo_of [2] = '{0, 4};

  function automatic mdl_t upd(mdl_t s, int lo,
                               bit e, bit f, bit t, int o);
    mdl_t n = s;
    n.fl = 1'b0;
    if (f && !s.drn) n.ov = 1'b1;
    if (!s.act) begin
      if (!e) begin n.act = 1'b1; n.age = 0; end
    end else if (!s.drn) begin
      if (e) n.act = 1'b0;
      else if (o >= HI || f) begin
        n.drn = 1'b1; n.pace = 0;
      end else if (TO_EN && s.age == TMO - 1) begin
        n.drn = 1'b1; n.pace = 0; n.fl = 1'b1;
      end else n.age = s.age + 1;
    end else if (s.pace == 2) n.pace = 1;
    else if (s.pace == 1) n.pace = 0;
    else if (e) begin n.act = 1'b0; n.drn = 1'b0; end
    else if (lo > 0 && o <= lo) begin
      n.drn = 1'b0; n.age = 0;
    end else if (t) n.pace = 2;
    n.rd = n.drn && (n.pace == 2);
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, act, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) m[k] = '{default: 0};
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      m[k] = upd(m[k], lo_of[k], empty, full, txr,
                 int'(occ));
    @(negedge clk);
    chk("u0.rd_en", rd0, m[0].rd);
    chk("u0.draining", dr0, m[0].drn);
    chk("u0.flush_evt", fl0, m[0].fl);
    chk("u0.ovf", ov0, m[0].ov);
    chk("u1.rd_en", rd1, m[1].rd);
    chk("u1.draining", dr1, m[1].drn);
    chk("u1.flush_evt", fl1, m[1].fl);
    chk("u1.ovf", ov1, m[1].ov);
  endtask

  // FIFO stand-in: pops follow instance fo's predicted strobe.
  task automatic env_step(int fo);
    step();
    if (m[fo].rd && occ != 0) occ = occ - 1'b1;
    empty = (occ == 0);
    full = (occ == 5'd31);
  endtask

  task automatic go_idle();
    occ = '0; empty = 1'b1; full = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int n;
    int first;
    int fls;
    int pm;
    mreset();
    #1;
    chk("rst.rd_en", rd0, 1'b0);
    chk("rst.draining", dr0, 1'b0);
    chk("rst.flush", fl0, 1'b0);
    chk("rst.ovf", ov0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();

    // watermark drain, LO_MARK 0 runs to empty
    txr = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      occ = 5'(k); empty = 1'b0;
      step();
    end
    chk("wm.draining", dr0, 1'b1);
    n = 0;
    for (int i = 0; i < 200 && m[0].act; i++) begin
      env_step(0);
      if (rd0 === 1'b1) n++;
    end
    chk("wm.pops", n, 16);
    chk("wm.end_draining", dr0, 1'b0);

    // overflow while filling, then empty+HI priority
    go_idle();
    occ = 5'd5; empty = 1'b0;
    repeat (2) step();
    chk("ovf.before", ov0, 1'b0);
    occ = 5'd31; full = 1'b1;
    step();
    chk("ovf.set", ov0, 1'b1);
    chk("ovf.drain", dr0, 1'b1);
    full = 1'b0; occ = 5'd5;
    repeat (5) step();
    chk("ovf.sticky", ov0, 1'b1);
    go_idle();
    occ = 5'd5; empty = 1'b0;
    repeat (2) step();
    occ = 5'd16; empty = 1'b1;
    n = 0;
    repeat (4) begin
      step();
      if (rd0 === 1'b1) n++;
    end
    chk("prio.draining", dr0, 1'b0);
    chk("prio.pops", n, 0);

    // asynchronous reset during a pop
    occ = 5'd20; empty = 1'b0; txr = 1'b1;
    for (int i = 0; i < 50 && !m[0].rd; i++) env_step(0);
    chk("rstpop.pre", rd0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstpop.rd_en", rd0, 1'b0);
    chk("rstpop.draining", dr0, 1'b0);
    chk("rstpop.ovf", ov0, 1'b0);
    mreset();
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // timeout flush with occ held at 3
    go_idle();
    occ = 5'd3; empty = 1'b0; txr = 1'b1;
    n = 0; first = 0; fls = 0;
    for (int i = 1; i <= (TO_EN ? 1100 : 5000); i++) begin
      env_step(0);
      if (rd0 === 1'b1) n++;
      if (fl0 === 1'b1) begin
        fls++;
        if (first == 0) first = i;
      end
    end
    chk("to.first", first, TO_EN ? 1001 : 0);
    chk("to.flushes", fls, TO_EN ? 1 : 0);
    chk("to.pops", n, TO_EN ? 3 : 0);

    // hysteresis on the LO_MARK=4 instance
    go_idle();
    txr = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      occ = 5'(k); empty = 1'b0;
      step();
    end
    n = 0;
    for (int i = 0; i < 200 && m[1].drn; i++) begin
      env_step(1);
      if (rd1 === 1'b1) n++;
    end
    chk("hy.pops", n, 12);
    chk("hy.stop", dr1, 1'b0);
    for (int k = 5; k <= 16; k++) begin
      occ = 5'(k);
      step();
    end
    chk("hy.restart", dr1, 1'b1);
    txr = 1'b0;
    n = 0;
    repeat (50) begin
      env_step(1);
      if (rd1 === 1'b1) n++;
    end
    chk("hy.stall", n, 0);
    txr = 1'b1;
    n = 0; pm = 0;
    repeat (9) begin
      env_step(1);
      if (rd1 === 1'b1) n++;
      if (m[1].rd) pm++;
    end
    chk("hy.resume", n, 3);
    chk("hy.resume_m", n, pm);

    // random inputs
    for (int i = 0; i < 3000; i++) begin
      int r;
      occ = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 15);
      empty = (occ == 0) || (r == 0);
      full = (occ == 5'd31) || (r == 1);
      txr = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Parametrised drain controller sitting between a receive FIFO and the UART transmitter in the image-processing datapath. It watches FIFO occupancy and flags, decides when to start and stop emptying the FIFO using high/low watermarks, and pops words one at a time, paced by the transmitter's ready handshake. An optional timeout flushes partially filled FIFOs that never reach the high watermark.

## Interface
- CNT_W, 5: width of the occupancy input.
- HI_MARK, 16: occupancy at or above which draining starts. Legal range is LO_MARK < HI_MARK ≤ 2^CNT_W−1.
- LO_MARK, 0: occupancy at or below which draining stops.
- TIMEOUT, 1000: cycles spent in FILL before a forced drain. Must be ≥ 2.
- TO_W, 16: timer width. Must satisfy 2^TO_W > TIMEOUT.
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- occ  in  CNT_W  current FIFO word count.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- tx_ready  in  1  transmitter can accept a word.
- rd_en  out  1  one-cycle pop strobe to the FIFO.
- draining  out  1  high while a drain burst is in progress.
- flush_evt  out  1  one-cycle pulse when a drain was forced by timeout.
- ovf  out  1  sticky flag: fifo_full was seen while not draining.

## Operation
- FSM states:
  - IDLE: timer=0. If !fifo_empty → FILL.
  - FILL: timer increments each cycle, starting at 0 on entry. Evaluate conditions in this priority order:
    1. fifo_empty → IDLE.
    2. occ ≥ HI_MARK or fifo_full → DRAIN.
    3. timer == TIMEOUT−1 → DRAIN, and pulse flush_evt.
    4. Otherwise stay in FILL.
  - DRAIN: evaluate in this priority order:
    1. fifo_empty → IDLE.
    2. LO_MARK > 0 and occ ≤ LO_MARK → FILL (timer cleared).
    3. tx_ready → POP.
    4. Otherwise stay in DRAIN.
  - POP: rd_en=1 for exactly this cycle. Always → GAP.
  - GAP: one settle cycle so occ and tx_ready can update. Always → DRAIN.
- draining = 1 in DRAIN, POP and GAP; 0 otherwise.
- ovf is set when fifo_full=1 in IDLE or FILL. Only reset clears it.
- All outputs are registered, with no combinational path from inputs to outputs.
- No arithmetic on occ other than unsigned compares. The timer saturates and does not wrap, and it is held at 0 outside FILL.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=IDLE, timer=0.
  - rd_en=0, draining=0, flush_evt=0, ovf=0.
  - Outputs drop immediately, including mid-POP; no partial pop is completed.
- Reset release: the first transition can occur at the first rising edge with reset_n=1.
- IDLE→FILL happens 1 cycle after fifo_empty is sampled low.
- Watermark start: draining rises 1 cycle after occ ≥ HI_MARK is sampled.
- Timeout: entering FILL at edge N gives DRAIN at edge N+TIMEOUT. flush_evt is high in that first DRAIN cycle only.
- Simultaneous HI_MARK and timeout in the same cycle → DRAIN without flush_evt.
- Simultaneous fifo_empty with any other FILL or DRAIN condition → IDLE.
- Pop pacing: with tx_ready held high, rd_en pulses every 3 cycles (DRAIN→POP→GAP). Minimum pop-to-pop spacing is 3 cycles.
- tx_ready low in DRAIN: the FSM waits indefinitely, with no timeout while draining.
- LO_MARK=0: draining continues until fifo_empty. The last pop is followed by GAP, then DRAIN sees empty, then IDLE.

## Configuration
- DRAIN_TIMEOUT_EN defined:
  - Timer and timeout transition are present as described above.
- DRAIN_TIMEOUT_EN undefined:
  - No timer is instantiated; TIMEOUT and TO_W are ignored.
  - FILL leaves only on empty, HI_MARK or full.
  - flush_evt is tied to 0.

## Test plan
- Reset mid-burst: assert reset_n=0 during POP → rd_en, draining, ovf go 0 asynchronously; after release the FSM is in IDLE with occ unchanged.
- Watermark drain: occ ramps 0→16 with tx_ready=1 → draining rises one cycle after occ=16. rd_en pulses every 3 cycles; the bench decrements occ per pop. After occ reaches 0 and empty is asserted, draining falls and the FSM returns to IDLE.
- Timeout flush (macro on): occ=3 held, empty=0 → after exactly 1000 cycles in FILL, flush_evt pulses once and draining=1; 3 pops are issued.
- Timeout disabled (macro off): same stimulus for 5000 cycles → draining=0, flush_evt=0, rd_en never asserted.
- Hysteresis with LO_MARK=4: drain from 16 → draining falls when occ=4, FILL resumes, and draining restarts at 16 again. Dropping tx_ready for 50 cycles during the drain → no rd_en for that period and pops resume afterwards.
- Overflow and priority: fifo_full=1 while in FILL → ovf=1 sticky and DRAIN is entered. Empty and HI_MARK asserted in the same cycle → IDLE, no pop.
